// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the LastGrant register lives in the parent.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic Winner,
  output logic AnyReq
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    AnyReq = Req0 | Req1;
    Winner = REQ0;
    if (Req0 && Req1) begin
      Winner = ~LastGrant;
    end else if (Req1) begin
      Winner = REQ1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one synchronous single-port memory
// between two requesters; read data is routed back to the owning requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AddrWidth = ADDR_W,
  parameter int DataWidth = DATA_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Req0,
  input  logic                 Wr0,
  input  logic [AddrWidth-1:0] Addr0,
  input  logic [DataWidth-1:0] WData0,
  output logic                 Ack0,
  output logic                 RValid0,
  output logic [DataWidth-1:0] RData0,
  input  logic                 Req1,
  input  logic                 Wr1,
  input  logic [AddrWidth-1:0] Addr1,
  input  logic [DataWidth-1:0] WData1,
  output logic                 Ack1,
  output logic                 RValid1,
  output logic [DataWidth-1:0] RData1,
  output logic                 Mem_Valid,
  output logic                 Mem_R_W,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_Din,
  input  logic [DataWidth-1:0] Mem_Dout,
  output logic                 Busy
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       winner;
  logic       any_req;

  rr_arbiter2 u_rr (
    .Req0      (Req0),
    .Req1      (Req1),
    .LastGrant (last_grant),
    .Winner    (winner),
    .AnyReq    (any_req)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one ISSUE cycle per access, plus CAPTURE for reads.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = Mem_R_W ? IDLE : CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory command, grant bookkeeping and read-data return.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_grant <= REQ1;
      grant      <= REQ0;
      Mem_Valid  <= 1'b0;
      Mem_R_W    <= 1'b0;
      Mem_Addr   <= '0;
      Mem_Din    <= '0;
      RValid0    <= 1'b0;
      RValid1    <= 1'b0;
      RData0     <= '0;
      RData1     <= '0;
    end else begin
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            Mem_Valid  <= 1'b1;
            Mem_R_W    <= (winner == REQ1) ? Wr1    : Wr0;
            Mem_Addr   <= (winner == REQ1) ? Addr1  : Addr0;
            Mem_Din    <= (winner == REQ1) ? WData1 : WData0;
          end
        end
        ISSUE: begin
          Mem_Valid <= 1'b0;
        end
        CAPTURE: begin
          if (grant == REQ1) begin
            RData1  <= Mem_Dout;
            RValid1 <= 1'b1;
          end else begin
            RData0  <= Mem_Dout;
            RValid0 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Ack and Busy decode from state/grant only, so there is no Req-to-output path.
  always_comb begin
    Ack0 = (state == ISSUE) && (grant == REQ0);
    Ack1 = (state == ISSUE) && (grant == REQ1);
    Busy = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts every Ack and RValid;
// a separate monitor compares DUT outputs against the queued expectations.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0 = 1'b0, Wr0 = 1'b0, Req1 = 1'b0, Wr1 = 1'b0;
  logic [7:0]  Addr0 = '0, Addr1 = '0;
  logic [31:0] WData0 = '0, WData1 = '0;
  logic        Ack0, RValid0, Ack1, RValid1;
  logic [31:0] RData0, RData1;
  logic        Mem_Valid, Mem_R_W, Busy;
  logic [7:0]  Mem_Addr;
  logic [31:0] Mem_Din;
  bit   [31:0] Mem_Dout;

  mem_port_arbiter #(.AddrWidth(8), .DataWidth(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Wr0(Wr0), .Addr0(Addr0), .WData0(WData0),
    .Ack0(Ack0), .RValid0(RValid0), .RData0(RData0),
    .Req1(Req1), .Wr1(Wr1), .Addr1(Addr1), .WData1(WData1),
    .Ack1(Ack1), .RValid1(RValid1), .RData1(RData1),
    .Mem_Valid(Mem_Valid), .Mem_R_W(Mem_R_W), .Mem_Addr(Mem_Addr),
    .Mem_Din(Mem_Din), .Mem_Dout(Mem_Dout), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Synchronous single-port memory attached to the arbiter.
  bit [31:0] mem [256];
  always @(posedge Clk) begin
    if (Mem_Valid) begin
      if (Mem_R_W) mem[Mem_Addr] <= Mem_Din;
      else         Mem_Dout      <= mem[Mem_Addr];
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  typedef struct {
    int         cyc;
    int         id;
    logic       wr;
    logic [7:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [31:0] data;
  } txn_t;

  exp_t ack_q[$];
  exp_t rv_q[$];
  txn_t dq0[$], dq1[$];

  // Reference model state (abstract: a free-at time and the last winner).
  bit [31:0] refmem [256];
  int        free_at = 0;
  int        last = 1;
  int        busy_from = 1, busy_to = 0;
  int        grant_cyc [2];
  bit        pending [2];
  bit        granted [2];
  int        done_at [2];
  logic      req_v [2];
  logic      wr_v [2];
  logic [7:0] addr_v [2];
  logic [31:0] data_v [2];
  bit        rnd_mode = 0;
  bit        started = 0;

  // Monitor-side held expectations.
  logic [31:0] rd_exp [2];
  logic        hold_rw = 1'b0;
  logic [7:0]  hold_addr = '0;
  logic [31:0] hold_din = '0;

  task automatic load(int i, txn_t t);
    pending[i] = 1; granted[i] = 0; req_v[i] = 1'b1;
    wr_v[i] = t.wr; addr_v[i] = t.addr; data_v[i] = t.data;
  endtask

  // One cycle of stimulus plus prediction, called at the falling edge.
  task automatic step();
    int c = cyc;
    int w;
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      if (pending[i] && granted[i] && c >= done_at[i]) pending[i] = 0;
      if (!pending[i]) begin
        if (i == 0 && dq0.size() > 0) load(0, dq0.pop_front());
        else if (i == 1 && dq1.size() > 0) load(1, dq1.pop_front());
        else if (rnd_mode && $urandom_range(0, 2) != 0) begin
          t.wr = 1'($urandom_range(0, 1)); t.addr = 8'($urandom_range(0, 15)); t.data = $urandom;
          load(i, t);
        end else if (c < free_at && $urandom_range(0, 3) == 0) begin
          // Glitch while the arbiter is busy: must be ignored.
          req_v[i] = 1'b1; wr_v[i] = 1'($urandom_range(0, 1));
          addr_v[i] = 8'($urandom); data_v[i] = $urandom;
        end else begin
          req_v[i] = 1'b0;
        end
      end
    end
    Req0 = req_v[0]; Wr0 = wr_v[0]; Addr0 = addr_v[0]; WData0 = data_v[0];
    Req1 = req_v[1]; Wr1 = wr_v[1]; Addr1 = addr_v[1]; WData1 = data_v[1];
    if (c >= free_at && (pending[0] || pending[1])) begin
      if (pending[0] && pending[1]) w = (last == 0) ? 1 : 0;
      else w = pending[1] ? 1 : 0;
      last = w; granted[w] = 1; done_at[w] = c + 1; grant_cyc[w] = c;
      ack_q.push_back('{c + 1, w, wr_v[w], addr_v[w], data_v[w]});
      busy_from = c + 1;
      if (wr_v[w]) begin
        refmem[addr_v[w]] = data_v[w];
        free_at = c + 2; busy_to = c + 1;
      end else begin
        rv_q.push_back('{c + 3, w, 1'b0, addr_v[w], refmem[addr_v[w]]});
        free_at = c + 3; busy_to = c + 2;
      end
    end
  endtask

  function automatic bit model_idle();
    return !pending[0] && !pending[1] && dq0.size() == 0 && dq1.size() == 0 &&
           cyc >= free_at && ack_q.size() == 0 && rv_q.size() == 0;
  endfunction

  // Step until all queued work has completed; starts at a falling edge.
  task automatic run(int budget);
    step();
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      if (model_idle()) return;
      step();
    end
    chk("timeout", 64'(cyc), 64'(free_at));
  endtask

  // Asynchronous reset: outputs checked 1 time unit after assertion.
  task automatic do_reset();
    Reset = 1'b1;
    started = 1;
    #1;
    chk("rst_ack", {Ack1, Ack0}, 0);
    chk("rst_rvalid", {RValid1, RValid0}, 0);
    chk("rst_rdata0", RData0, 0);
    chk("rst_rdata1", RData1, 0);
    chk("rst_mem", {Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din}, 0);
    chk("rst_busy", Busy, 0);
    ack_q.delete(); rv_q.delete(); dq0.delete(); dq1.delete();
    for (int i = 0; i < 2; i++) begin
      pending[i] = 0; granted[i] = 0; req_v[i] = 1'b0; rd_exp[i] = '0; grant_cyc[i] = -100;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    hold_rw = 1'b0; hold_addr = '0; hold_din = '0;
    last = 1; busy_from = 1; busy_to = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    free_at = cyc;
  endtask

  // Monitor: compares every cycle against the head of the expectation queues.
  always @(posedge Clk) begin
    #2;
    if (started && !Reset) begin
      bit av, rv;
      int aid, rid;
      av  = ack_q.size() > 0 && ack_q[0].cyc == cyc;
      aid = av ? ack_q[0].id : 2;
      chk("ack0", Ack0, av && aid == 0);
      chk("ack1", Ack1, av && aid == 1);
      chk("mem_valid", Mem_Valid, av);
      if (av) begin
        hold_rw = ack_q[0].wr; hold_addr = ack_q[0].addr; hold_din = ack_q[0].data;
        void'(ack_q.pop_front());
      end
      chk("mem_r_w", Mem_R_W, hold_rw);
      chk("mem_addr", Mem_Addr, hold_addr);
      chk("mem_din", Mem_Din, hold_din);
      rv  = rv_q.size() > 0 && rv_q[0].cyc == cyc;
      rid = rv ? rv_q[0].id : 2;
      chk("rvalid0", RValid0, rv && rid == 0);
      chk("rvalid1", RValid1, rv && rid == 1);
      if (rv) begin
        rd_exp[rid] = rv_q[0].data;
        void'(rv_q.pop_front());
      end
      chk("rdata0", RData0, rd_exp[0]);
      chk("rdata1", RData1, rd_exp[1]);
      chk("busy", Busy, cyc >= busy_from && cyc <= busy_to);
    end
  end

  initial begin
    @(negedge Clk);
    do_reset();

    // Single write from requester 0, then read-back by requester 1.
    dq0.push_back('{1'b1, 8'h05, 32'hDEADBEEF});
    run(50);
    dq1.push_back('{1'b0, 8'h05, 32'h0});
    run(50);

    // Requester 0 alone: back-to-back writes then ordered read-back.
    for (int i = 0; i < 4; i++) dq0.push_back('{1'b1, 8'(i), 32'(10 + i)});
    for (int i = 0; i < 4; i++) dq0.push_back('{1'b0, 8'(i), 32'h0});
    run(100);

    // Both requesters reading continuously from reset: strict alternation.
    do_reset();
    for (int i = 0; i < 3; i++) dq0.push_back('{1'b0, 8'(i), 32'h0});
    dq1.push_back('{1'b0, 8'h03, 32'h0});
    dq1.push_back('{1'b0, 8'h05, 32'h0});
    dq1.push_back('{1'b0, 8'h02, 32'h0});
    run(100);

    // Reset during CAPTURE of a requester 1 read: the RValid1 must never appear.
    dq1.push_back('{1'b0, 8'h01, 32'h0});
    step();
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (grant_cyc[1] >= 0 && cyc == grant_cyc[1] + 2) break;
      step();
    end
    chk("capture_reached", 64'(cyc), 64'(grant_cyc[1] + 2));
    do_reset();
    dq0.push_back('{1'b0, 8'h02, 32'h0});
    dq1.push_back('{1'b0, 8'h03, 32'h0});
    run(50);

    // Randomized traffic with busy-time glitches on idle requesters.
    rnd_mode = 1;
    step();
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      step();
    end
    rnd_mode = 0;
    @(negedge Clk);
    run(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
